riscv_div: RTL and testbench



---
 rtl/riscv_div.sv | 143 ++++++++++++++
 tb/tb_riscv_div.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; start/busy/done handshake toward the pipeline.
module riscv_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            div_sel,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out
);

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int W  = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  rem;
    logic [W-1:0]  quot;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          op_rem;
    logic          neg_q;
    logic          neg_r;

    logic          sel_signed;
    logic          sel_rem;
    logic          s1;
    logic          s2;
    logic [W-1:0]  mag1;
    logic [W-1:0]  mag2;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic [W-1:0]  rem_n;
    logic [W-1:0]  quot_n;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;
    logic          last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (last) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == FINISH);
    assign last = (cnt == CW'(1));

    always_comb begin
        sel_signed = 1'b0;
        sel_rem    = 1'b0;
        unique case (div_sel)
            DIV:  begin sel_signed = 1'b1; sel_rem = 1'b0; end
            DIVU: begin sel_signed = 1'b0; sel_rem = 1'b0; end
            REM:  begin sel_signed = 1'b1; sel_rem = 1'b1; end
            REMU: begin sel_signed = 1'b0; sel_rem = 1'b1; end
            default: ;
        endcase
    end

    // Magnitude of the most negative value wraps to 2^(W-1) unsigned.
    assign s1   = sel_signed & in1[W-1];
    assign s2   = sel_signed & in2[W-1];
    assign mag1 = s1 ? -in1 : in1;
    assign mag2 = s2 ? -in2 : in2;

    always_comb begin
        shifted = {rem, quot[W-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[W]) begin
            rem_n  = diff[W-1:0];
            quot_n = {quot[W-2:0], 1'b1};
        end else begin
            rem_n  = shifted[W-1:0];
            quot_n = {quot[W-2:0], 1'b0};
        end
        q_fix = neg_q ? -quot_n : quot_n;
        r_fix = neg_r ? -rem_n : rem_n;
    end

    // Divide-by-zero falls out of the loop (all-ones / dividend) as long
    // as the quotient is never negated for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quot   <= '0;
            dvs    <= '0;
            cnt    <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            out    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem    <= '0;
                        quot   <= mag1;
                        dvs    <= mag2;
                        cnt    <= CW'(W);
                        op_rem <= sel_rem;
                        neg_q  <= (s1 ^ s2) & (in2 != '0);
                        neg_r  <= s1;
                    end
                end
                BUSY: begin
                    rem  <= rem_n;
                    quot <= quot_n;
                    cnt  <= cnt - CW'(1);
                    if (last) out <= op_rem ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div.sv
// Randomized self-checking bench for riscv_div against an arithmetic model.
// Covers latency, handshake, reset abort and RISC-V special cases.
module tb_riscv_div;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   div_sel;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;

    int total;
    int bad;

    riscv_div #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .div_sel (div_sel),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb;
        longint ua, ub;
        if (b == '0) return op[1] ? a : '1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00:   return W'(sa / sb);
            2'b01:   return W'(ua / ub);
            2'b10:   return W'(sa % sb);
            default: return W'(ua % ub);
        endcase
    endfunction

    // Runs one division from IDLE; returns result, done latency in cycles
    // after the accepting edge, and handshake observations.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] res,
                         output int lat, output bit busy_ok,
                         output bit hold_ok, output bit pulse_ok);
        logic [W-1:0] prev;
        prev    = out;
        div_sel = op;
        in1     = a;
        in2     = b;
        start   = 1'b1;
        @(posedge clk);
        lat     = -1;
        res     = '0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                res = out;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (out !== prev) hold_ok = 1'b0;
        end
        @(negedge clk);
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic check_op(input string name, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] want);
        logic [W-1:0] res;
        int lat;
        bit b_ok, h_ok, p_ok;
        do_op(op, a, b, res, lat, b_ok, h_ok, p_ok);
        total++;
        if (res !== want) begin
            bad++;
            $display("FAIL %s result: got %h want %h", name, res, want);
        end
        total++;
        if (lat !== W + 1) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
        end
        total++;
        if (!(b_ok && h_ok && p_ok)) begin
            bad++;
            $display("FAIL %s handshake: busy=%0b hold=%0b pulse=%0b want 111",
                     name, b_ok, h_ok, p_ok);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        div_sel = 2'b00;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, out} !== {2'b00, {W{1'b0}}}) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b out=%h want 0 0 0",
                     busy, done, out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        div_sel = 2'b01;
        in1     = 32'd100;
        in2     = 32'd7;
        start   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, out} !== {2'b00, {W{1'b0}}}) begin
            bad++;
            $display("FAIL abort: got busy=%b done=%b out=%h want 0 0 0",
                     busy, done, out);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet: got activity=1 want 0");
        end
        check_op("after_abort", 2'b01, 32'd100, 32'd7, 32'd14);
    endtask

    task automatic test_unsigned;
        check_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
        check_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        check_op("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    endtask

    task automatic test_signed;
        check_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 32'hFFFFFFFD);
        check_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF);
        check_op("div_7_m2", 2'b00, 32'd7, -32'sd2, 32'hFFFFFFFD);
        check_op("rem_7_m2", 2'b10, 32'd7, -32'sd2, 32'd1);
    endtask

    task automatic test_div_zero;
        check_op("div_by0", 2'b00, 32'd1234, 32'd0, 32'hFFFFFFFF);
        check_op("remu_by0", 2'b11, 32'd1234, 32'd0, 32'd1234);
        check_op("div_neg_by0", 2'b00, -32'sd5, 32'd0, 32'hFFFFFFFF);
        check_op("rem_neg_by0", 2'b10, -32'sd5, 32'd0, -32'sd5);
    endtask

    task automatic test_overflow;
        check_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        check_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    endtask

    task automatic test_random;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(1, 20));
                1:       b = -W'($urandom_range(1, 20));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            check_op("random", op, a, b, model(op, a, b));
        end
    endtask

    task automatic test_busy_start;
        logic [W-1:0] want;
        int lat;
        want    = model(2'b00, -32'sd1000, 32'd7);
        div_sel = 2'b00;
        in1     = -32'sd1000;
        in2     = 32'd7;
        start   = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == 5 || k == 20) begin
                start   = 1'b1;
                div_sel = 2'($urandom_range(0, 3));
                in1     = $urandom;
                in2     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (lat !== W + 1 || out !== want) begin
            bad++;
            $display("FAIL busy_start: got lat=%0d out=%h want lat=%0d out=%h",
                     lat, out, W + 1, want);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a[3];
        logic [W-1:0] b[3];
        logic [1:0]   op[3];
        int           when[3];
        logic [W-1:0] got[3];
        logic [W-1:0] held;
        int n;
        bit stable;
        for (int i = 0; i < 3; i++) begin
            op[i] = 2'($urandom_range(0, 3));
            a[i]  = $urandom;
            b[i]  = W'($urandom_range(1, 1000));
            when[i] = -1;
            got[i]  = '0;
        end
        n       = 0;
        stable  = 1'b1;
        held    = out;
        div_sel = op[0];
        in1     = a[0];
        in2     = b[0];
        start   = 1'b1;
        for (int c = 1; c <= 120 && n < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                when[n] = c;
                got[n]  = out;
                held    = out;
                n++;
                if (n < 3) begin
                    div_sel = op[n];
                    in1     = a[n];
                    in2     = b[n];
                end else begin
                    start = 1'b0;
                end
            end else if (out !== held) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== model(op[i], a[i], b[i])) begin
                bad++;
                $display("FAIL b2b_result%0d: got %h want %h", i, got[i],
                         model(op[i], a[i], b[i]));
            end
        end
        total++;
        if (when[0] !== W + 1 || when[1] - when[0] !== W + 2 ||
            when[2] - when[1] !== W + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d %0d %0d want %0d %0d %0d",
                     when[0], when[1], when[2], W + 1, 2 * W + 3, 3 * W + 5);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL b2b_hold: got out_changed=1 want 0");
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulse: got done=%b want 0", done);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_reset_mid_op();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
